// File: rtl/collapsering_sampler.sv
// ----------------------------------------------------------------------------
// collapsering_sampler : collapsing ring oscillator sequencer and harvester
// Runs NUM_RINGS rings, times their collapse, packs edge-count LSBs into words.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module collapsering_sampler #(
  parameter int NUM_RINGS    = 4,
  parameter int TRIM_BITS    = 28,
  parameter int CNT_BITS     = 16,
  parameter int ARM_CYCLES   = 8,
  parameter int QUIET_CYCLES = 4,
  parameter int OUT_BITS     = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable,
  input  logic                 continuous,
  input  logic [TRIM_BITS-1:0] trim_a,
  input  logic [TRIM_BITS-1:0] trim_b,
  input  logic [CNT_BITS-1:0]  max_cycles,
  input  logic [NUM_RINGS-1:0] ring_clk_i,
  output logic [NUM_RINGS-1:0] ring_start_o,
  output logic [TRIM_BITS-1:0] ring_trim_a_o,
  output logic [TRIM_BITS-1:0] ring_trim_b_o,
  output logic [OUT_BITS-1:0]  data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic [7:0]           timeout_cnt_o,
  output logic                 busy_o
);

  localparam int ARM_W  = $clog2(ARM_CYCLES + 1);
  localparam int QW     = $clog2(QUIET_CYCLES + 1);
  localparam int FILL_W = $clog2(OUT_BITS + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_HARVEST = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 en_q, pend_q;
  logic [ARM_W-1:0]     arm_cnt_q;
  logic [CNT_BITS-1:0]  run_cnt_q;
  logic [TRIM_BITS-1:0] trim_a_q, trim_b_q;
  logic [OUT_BITS-1:0]  acc_q, data_q;
  logic [FILL_W-1:0]    fill_q;
  logic                 valid_q;
  logic [7:0]           tout_q;
  logic [NUM_RINGS-1:0] ring_s1_q, ring_s2_q, ring_s3_q;

  logic [NUM_RINGS-1:0] w_edge, w_bits, w_done_d;
  logic [OUT_BITS-1:0]  w_acc_shift;
  logic [FILL_W-1:0]    w_fill_inc;
  logic [CNT_BITS-1:0]  w_max_eff, w_run_inc;
  logic                 w_all_done, w_run_hit, w_word_full, w_out_free;
  logic                 w_xfer, w_timeout, w_abort;
  logic [2:0]           w_after;

  assign w_edge      = ring_s2_q & ~ring_s3_q;
  assign w_all_done  = &w_done_d;
  assign w_max_eff   = (max_cycles == '0) ? '1 : max_cycles;
  assign w_run_inc   = run_cnt_q + 1'b1;
  assign w_run_hit   = (w_run_inc == w_max_eff);
  assign w_fill_inc  = fill_q + FILL_W'(NUM_RINGS);
  assign w_word_full = (w_fill_inc == FILL_W'(OUT_BITS));
  assign w_out_free  = !valid_q || data_ready_i;
  assign w_after     = (continuous && enable) ? S_ARM : S_IDLE;
  assign w_xfer      = ((state_q == S_HARVEST) && w_word_full && w_out_free) ||
                       ((state_q == S_HOLD) && w_out_free);
  assign w_timeout   = (state_q == S_RUN) && enable && !w_all_done && w_run_hit;
  assign w_abort     = ((state_q == S_ARM) || (state_q == S_RUN)) && !enable;

  if (OUT_BITS > NUM_RINGS) begin : g_acc_shift
    assign w_acc_shift = {acc_q[OUT_BITS-NUM_RINGS-1:0], w_bits};
  end else begin : g_acc_direct
    assign w_acc_shift = w_bits;
  end

  // Per-ring collapse detection: done once QUIET_CYCLES edge-free cycles elapse
  for (genvar gi = 0; gi < NUM_RINGS; gi++) begin : g_ring
    logic [CNT_BITS-1:0] edge_cnt_q;
    logic [QW-1:0]       quiet_q, quiet_d;

    always_comb begin
      quiet_d = quiet_q;
      if (w_edge[gi])
        quiet_d = '0;
      else if (quiet_q != QW'(QUIET_CYCLES))
        quiet_d = quiet_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || state_q == S_ARM) begin
        edge_cnt_q <= '0;
        quiet_q    <= '0;
      end else if (state_q == S_RUN) begin
        quiet_q <= quiet_d;
        if (w_edge[gi] && edge_cnt_q != '1)
          edge_cnt_q <= edge_cnt_q + 1'b1;
      end
    end

    assign w_bits[gi]   = edge_cnt_q[0];
    assign w_done_d[gi] = (quiet_d == QW'(QUIET_CYCLES));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable && (continuous || pend_q)) state_d = S_ARM;
      S_ARM: begin
        if (!enable)                                    state_d = S_IDLE;
        else if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1))  state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable)         state_d = S_IDLE;
        else if (w_all_done) state_d = S_HARVEST;
        else if (w_run_hit)  state_d = S_ARM;
      end
      S_HARVEST: state_d = (w_word_full && !w_out_free) ? S_HOLD : w_after;
      S_HOLD:    if (w_out_free) state_d = w_after;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ring_start_o = {NUM_RINGS{state_q == S_RUN}};
    busy_o       = (state_q != S_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      arm_cnt_q <= '0;
      run_cnt_q <= '0;
      trim_a_q  <= '0;
      trim_b_q  <= '0;
      acc_q     <= '0;
      fill_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      tout_q    <= '0;
      ring_s1_q <= '0;
      ring_s2_q <= '0;
      ring_s3_q <= '0;
    end else begin
      ring_s1_q <= ring_clk_i;
      ring_s2_q <= ring_s1_q;
      ring_s3_q <= ring_s2_q;
      en_q      <= enable;
      // A fresh enable edge outranks a word completing in the same cycle
      if (enable && !en_q) pend_q <= 1'b1;
      else if (w_xfer)     pend_q <= 1'b0;

      if (state_q != S_ARM && state_d == S_ARM) begin
        trim_a_q <= trim_a;
        trim_b_q <= trim_b;
      end

      arm_cnt_q <= (state_q == S_ARM) ? arm_cnt_q + 1'b1 : '0;
      if (state_q == S_ARM)      run_cnt_q <= '0;
      else if (state_q == S_RUN) run_cnt_q <= w_run_inc;

      if (w_abort) begin
        acc_q  <= '0;
        fill_q <= '0;
      end else if (state_q == S_HARVEST) begin
        acc_q  <= w_acc_shift;
        fill_q <= w_xfer ? '0 : w_fill_inc;
      end else if (w_xfer) begin
        fill_q <= '0;
      end

      if (w_xfer) begin
        data_q  <= (state_q == S_HOLD) ? acc_q : w_acc_shift;
        valid_q <= 1'b1;
      end else if (valid_q && data_ready_i) begin
        valid_q <= 1'b0;
      end

      if (w_timeout && tout_q != 8'hFF) tout_q <= tout_q + 1'b1;
    end
  end

  assign ring_trim_a_o = trim_a_q;
  assign ring_trim_b_o = trim_b_q;
  assign data_o        = data_q;
  assign data_valid_o  = valid_q;
  assign timeout_cnt_o = tout_q;

endmodule

`default_nettype wire

// File: tb/tb_collapsering_sampler.sv
// ----------------------------------------------------------------------------
// tb_collapsering_sampler : directed bench with behavioural collapsing rings
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_collapsering_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, continuous, data_ready;
  logic [27:0] trim_a, trim_b;
  logic [15:0] max_cycles;
  logic [3:0]  ring_clk = '0;
  logic [3:0]  ring_start;
  logic [27:0] trim_a_o, trim_b_o;
  logic [31:0] data_o;
  logic        data_valid;
  logic [7:0]  tout;
  logic        busy;

  logic [3:0]  ring_free  = '0;
  int          ring_extra = 0;
  int          ph [4]     = '{default: 0};
  int          run_total  = 0;
  logic        start_prev = 1'b0;

  int checks = 0;
  int errors = 0;

  collapsering_sampler dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .enable        (enable),
    .continuous    (continuous),
    .trim_a        (trim_a),
    .trim_b        (trim_b),
    .max_cycles    (max_cycles),
    .ring_clk_i    (ring_clk),
    .ring_start_o  (ring_start),
    .ring_trim_a_o (trim_a_o),
    .ring_trim_b_o (trim_b_o),
    .data_o        (data_o),
    .data_valid_o  (data_valid),
    .data_ready_i  (data_ready),
    .timeout_cnt_o (tout),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Ring i gives 10+i+ring_extra rising edges per run, or toggles forever when free
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ring_free[i]) begin
        ring_clk[i] = ~ring_clk[i];
      end else if (!ring_start[i]) begin
        ring_clk[i] = 1'b0;
        ph[i] = 0;
      end else if (ph[i] < 2 * (10 + i + ring_extra)) begin
        ring_clk[i] = ~ring_clk[i];
        ph[i] = ph[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    start_prev <= ring_start[0];
    if (ring_start[0] && !start_prev) run_total <= run_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!data_valid && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(data_valid), 64'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int k = 0;
    while (!ring_start[0] && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(ring_start[0]), 64'd1);
  endtask

  task automatic ready_pulse();
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
  endtask

  initial begin
    int base;
    int hi;
    int k;

    rst = 1'b1; enable = 1'b0; continuous = 1'b0; data_ready = 1'b0;
    trim_a = 28'h1234567; trim_b = 28'hABCDEF0; max_cycles = 16'd0;
    ring_free = 4'hF;
    tick(5);
    chk("rst_start", 64'(ring_start), 64'd0);
    chk("rst_trim_a", 64'(trim_a_o), 64'd0);
    chk("rst_trim_b", 64'(trim_b_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_tout", 64'(tout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    rst = 1'b0;
    tick(20);
    chk("idle_start", 64'(ring_start), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    ring_free = 4'h0;
    tick(10);

    // Continuous harvesting: counts 10,11,12,13 give bits 0xA per run
    continuous = 1'b1;
    base = run_total;
    enable = 1'b1;
    wait_valid("word1_wait", 2000);
    ring_extra = 1;
    chk("word1_data", 64'(data_o), 64'hAAAAAAAA);
    chk("word1_runs", 64'(run_total - base), 64'd8);
    chk("trim_a_out", 64'(trim_a_o), 64'h1234567);
    chk("trim_b_out", 64'(trim_b_o), 64'hABCDEF0);

    // Second word (0x55555555) must park in HOLD behind the unread first word
    k = 0;
    while ((run_total - base) < 16 && k < 2000) begin tick(1); k++; end
    k = 0;
    while (ring_start[0] && k < 200) begin tick(1); k++; end
    tick(60);
    chk("hold_start", 64'(ring_start), 64'd0);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_runs", 64'(run_total - base), 64'd16);
    chk("hold_data", 64'(data_o), 64'hAAAAAAAA);
    chk("hold_valid", 64'(data_valid), 64'd1);
    ready_pulse();
    chk("word2_data", 64'(data_o), 64'h55555555);
    chk("word2_valid", 64'(data_valid), 64'd1);

    // Abort mid-RUN after a partial word has accumulated
    base = run_total;
    k = 0;
    while ((run_total - base) < 3 && k < 2000) begin tick(1); k++; end
    chk("abort_run_seen", 64'(ring_start[0]), 64'd1);
    tick(5);
    enable = 1'b0;
    tick(1);
    chk("abort_start", 64'(ring_start), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data", 64'(data_o), 64'h55555555);
    chk("abort_valid", 64'(data_valid), 64'd1);
    ready_pulse();
    chk("drain_valid", 64'(data_valid), 64'd0);

    // Cleared fill: the next word needs a full eight runs again
    ring_extra = 0;
    base = run_total;
    enable = 1'b1;
    wait_valid("word3_wait", 2000);
    chk("word3_data", 64'(data_o), 64'hAAAAAAAA);
    chk("word3_runs", 64'(run_total - base), 64'd8);
    enable = 1'b0;
    tick(2);
    chk("word3_idle", 64'(busy), 64'd0);
    ready_pulse();

    // One-shot mode: one word per enable rising edge
    continuous = 1'b0;
    base = run_total;
    enable = 1'b1;
    wait_valid("oneshot1_wait", 2000);
    chk("oneshot1_data", 64'(data_o), 64'hAAAAAAAA);
    chk("oneshot1_runs", 64'(run_total - base), 64'd8);
    tick(200);
    chk("oneshot1_idle", 64'(busy), 64'd0);
    chk("oneshot1_norun", 64'(run_total - base), 64'd8);
    ready_pulse();
    chk("oneshot1_drain", 64'(data_valid), 64'd0);
    enable = 1'b0;
    tick(3);
    ring_extra = 1;
    enable = 1'b1;
    wait_valid("oneshot2_wait", 2000);
    chk("oneshot2_data", 64'(data_o), 64'h55555555);
    chk("oneshot2_runs", 64'(run_total - base), 64'd16);
    enable = 1'b0;
    ready_pulse();

    // Timeouts: ring 2 never collapses
    ring_extra = 0;
    ring_free = 4'b0100;
    max_cycles = 16'd100;
    continuous = 1'b1;
    data_ready = 1'b1;
    enable = 1'b1;
    wait_start("tmo_start_wait", 50);
    hi = 0;
    while (ring_start[0] && hi < 1000) begin
      hi++;
      tick(1);
    end
    chk("tmo_run_len", 64'(hi), 64'd100);
    chk("tmo_first", 64'(tout), 64'd1);
    k = 0;
    while (tout != 8'hFF && k < 30000) begin tick(1); k++; end
    chk("tmo_reach_255", 64'(tout), 64'hFF);
    tick(300);
    chk("tmo_saturate", 64'(tout), 64'hFF);
    chk("tmo_no_valid", 64'(data_valid), 64'd0);

    // Reset in the middle of a run
    wait_start("rstrun_wait", 200);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rstrun_start", 64'(ring_start), 64'd0);
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_tout", 64'(tout), 64'd0);
    chk("rstrun_trim", 64'(trim_a_o), 64'd0);
    chk("rstrun_data", 64'(data_o), 64'd0);
    rst = 1'b0;
    enable = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/collapsering_sampler.md
# collapsering_sampler

Multi-channel controller and entropy harvester for collapsing ring oscillators. Sequences the start/trim inputs of `NUM_RINGS` ring macros, measures each ring's collapse time on the system clock, and packs the LSB of each ring's edge count into `OUT_BITS`-wide random words delivered over a valid/ready handshake. Sits between the ring macros and the Wishbone register block of the randsack TRNG.

## Interface
- `NUM_RINGS`, 4: ring channels; `OUT_BITS` must be a multiple of it.
- `TRIM_BITS`, 28: trim width per ring, shared trim values.
- `CNT_BITS`, 16: edge and run-cycle counter width.
- `ARM_CYCLES`, 8: cycles start is held low before each run.
- `QUIET_CYCLES`, 4: consecutive edge-free cycles that define collapse.
- `OUT_BITS`, 32: output word width.

- `wb_clk_i` in 1: system clock; the block's only clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `enable` in 1: run request.
- `continuous` in 1: 1 = free-running, 0 = one word per enable rising edge.
- `trim_a`, `trim_b` in TRIM_BITS: trims, registered in ARM, held through RUN.
- `max_cycles` in CNT_BITS: RUN timeout; 0 means 2^CNT_BITS-1.
- `ring_clk_i` in NUM_RINGS: asynchronous ring outputs.
- `ring_start_o` out NUM_RINGS: start to every ring.
- `ring_trim_a_o`, `ring_trim_b_o` out TRIM_BITS: registered trims.
- `data_o` out OUT_BITS: random word.
- `data_valid_o` out 1: `data_o` valid.
- `data_ready_i` in 1: consumer accepts.
- `timeout_cnt_o` out 8: discarded-run counter, saturates at 255.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, ARM, RUN, HARVEST, HOLD.
- IDLE: `ring_start_o`=0. Leave for ARM when `enable`=1, and either `continuous`=1 or a registered rising edge of `enable` has occurred since the last word.
- ARM: start=0 for exactly ARM_CYCLES cycles. Trims are registered on ARM entry. Per-ring edge counters, quiet counters and the run counter are cleared.
- RUN: `ring_start_o` is all ones.
  - Each `ring_clk_i[i]` passes through a 2-flop synchronizer and rising-edge detector.
  - Each edge increments `edge_cnt[i]`, saturating, and resets `quiet[i]`. A cycle with no edge increments `quiet[i]`.
  - Ring i is done when `quiet[i]` reaches QUIET_CYCLES. A ring that never toggles is done with count 0.
  - The run counter increments every RUN cycle.
  - Exit to HARVEST when all rings are done.
  - If the run counter reaches `max_cycles` first, the run is a timeout: bits are discarded, `timeout_cnt_o` increments (saturating), and the FSM goes to ARM, or to IDLE if `enable`=0.
- HARVEST (1 cycle):
  - `acc <= {acc[OUT_BITS-NUM_RINGS-1:0], bits}`, where `bits[i] = edge_cnt[i][0]`.
  - `fill` increments by NUM_RINGS.
  - When `fill` reaches OUT_BITS, the word transfers to `data_o` if the output register is empty or being accepted this cycle. Otherwise go to HOLD.
  - After a transfer, `fill` is cleared.
  - Next state: ARM if `continuous`=1 and `enable`=1, else IDLE.
- HOLD: ring start=0. Wait until the output register frees, transfer, then apply the HARVEST next-state rule.
- `enable`=0 during ARM or RUN aborts: go to IDLE, start=0, `acc` and `fill` cleared. Pending `data_o` is kept.
- Output register: `data_valid_o` set on transfer, cleared on `data_valid_o && data_ready_i`. `data_o` stays stable while valid.

## Timing
- Reset, synchronous: state IDLE. All outputs are 0: `ring_start_o`, trims, `data_o`, `data_valid_o`, `timeout_cnt_o`, `busy_o`. `acc`, `fill` and all counters are 0.
- `ring_start_o` rises the cycle after ARM's last cycle and falls on the first HARVEST or timeout cycle.
- Minimum run length is ARM_CYCLES + QUIET_CYCLES + 1 (HARVEST) cycles. The synchronizer adds 2 cycles of edge latency.
- The first word appears OUT_BITS/NUM_RINGS runs after enable. `data_valid_o` rises the cycle after the HARVEST that completes the word.
- Simultaneous transfer and accept in the same cycle: the new word loads, and valid stays 1.
- `wb_rst_i` mid-RUN: start drops the next cycle and all state resets.

## Test plan
- Reset with all rings toggling → every output 0 and start low; after release with `enable`=0, start stays 0.
- Behavioural rings: ring i produces 10+i edges then stops; NUM_RINGS=4, OUT_BITS=32, continuous=1 → after 8 runs `data_valid_o`=1 with `data_o`=0xAAAAAAAA (bit pattern from count LSBs 0,1,0,1 per run).
- Ring 2 never collapses, `max_cycles`=100 → start is high exactly 100 cycles per run, `timeout_cnt_o` reaches 255 and holds, `data_valid_o` stays 0.
- `data_ready_i`=0 with word pending → FSM enters HOLD, start=0, `data_o` stable; `data_ready_i`=1 for one cycle → next word loads the following cycle.
- continuous=0: `enable` held high → exactly one word, then IDLE; drop and reassert `enable` → second word.
- Drop `enable` mid-RUN → start=0 the next cycle, `busy_o`=0, `fill` cleared, pending `data_o` unchanged.
